ball_split_ctrl: RTL and testbench
==================================

Name: ball_split_ctrl

Overview:
- Owns the pool of NUM_BALLS ball slots. Each slot is one ball-motion instance in the playfield.
- Sequences level start (spawns the first ball), rope hits (splits a ball into two smaller ones, or pops the smallest size), scoring and level-clear detection.
- Drives a one-cycle load bus that the ball-motion instances use to reinitialise position, direction and size.
- Sits between the rope/ball collision logic and the ball-motion bank.

Parameters:
- NUM_BALLS, 8: number of ball slots; the slot index is 3 bits.
- MAX_SIZE, 3: size of the ball spawned at level start. Sizes run 0 (smallest) to 3.
- INIT_X, 26: spawn X in pixels.
- INIT_Y, 26: spawn Y in pixels.
- SPLIT_OFS, 16: pixel offset of each child from the hit X.
- X_MAX, 639: right limit for child X.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous, active-high reset (port name kept per codebase; asserted = 1)
- startOfFrame  in  1  one-cycle pulse per frame; ball movers update on it
- level_start  in  1  pulse: clear the pool and spawn the first ball
- hit_valid  in  1  collision logic reports a rope hit
- hit_slot  in  3  slot that was hit
- hit_x  in  11  hit ball top-left X, pixels
- hit_y  in  11  hit ball top-left Y, pixels
- hit_ready  out  1  controller accepts a hit this cycle
- load_valid  out  1  one-cycle load strobe to the ball bank
- load_slot  out  3  slot being loaded
- load_x  out  11  new X
- load_y  out  11  new Y
- load_xdir  out  1  1 = moving right, 0 = moving left
- load_size  out  2  new size
- active_mask  out  8  bit i = slot i holds a live ball
- score  out  16  accumulated score
- level_clear  out  1  one-cycle pulse when the last ball pops
- overflow  out  1  one-cycle pulse when a child ball is dropped because no slot is free

Behaviour:
- Reset (resetN=1 at a clk edge):
  - state=IDLE; all outputs are 0.
  - Per-slot size registers are 0.
- All outputs are registered.
- States: IDLE, INIT, SPLIT_A, SPLIT_B, POP, CHECK.
- hit_ready = 1 only in IDLE when level_start=0.
- A hit is accepted when hit_valid & hit_ready.
  - If active_mask[hit_slot]=0, the hit is ignored (no state change).
  - Otherwise hit_slot, hit_x, hit_y and the slot size are latched.
- level_start in any state:
  - Next state is INIT.
  - active_mask is cleared.
  - Any in-progress split or pop is abandoned; no score and no level_clear result from it.
  - level_start takes priority over a simultaneous hit.
- INIT:
  - Load slot 0 with x=INIT_X, y=INIT_Y, xdir=1, size=MAX_SIZE.
  - Set active_mask[0].
  - Go to IDLE.
- Accepted hit with size > 0:
  - SPLIT_A: load the hit slot with size-1, xdir=0, x=max(hit_x-SPLIT_OFS, 0), y=hit_y.
  - SPLIT_B: find the lowest-index slot with active_mask=0, evaluated after SPLIT_A.
    - If found: load it with size-1, xdir=1, x=min(hit_x+SPLIT_OFS, X_MAX), y=hit_y, and set its active bit.
    - If none found: pulse overflow; no load.
  - Then go to IDLE.
  - score += 1.
- Accepted hit with size = 0:
  - POP: clear active_mask[hit_slot]; score += 4.
  - CHECK: if active_mask=0, pulse level_clear.
  - Then go to IDLE.
- Score saturates at 0xFFFF. It is cleared only by reset; level_start does not clear it.
- Load timing:
  - load_valid is never asserted in a cycle where startOfFrame=1.
  - A load-issuing state (INIT, SPLIT_A, SPLIT_B) seeing startOfFrame=1 stalls one cycle and issues the load on the next cycle.
  - The load fields are valid only while load_valid=1, and are held for that one cycle.
- Latency from the accept edge, no stalls:
  - Split: first load at cycle +1, second at +2, hit_ready high again at +3.
  - Pop: mask bit clears at +1, level_clear at +2, ready at +3.
- The size register for a slot is written on every load to that slot.
- Reset asserted mid-operation returns to IDLE on the next edge with all outputs at reset values.

Test Plan:
- Level start: reset, level_start -> one load_valid, slot 0, x=26, y=26, xdir=1, size=3; active_mask=0x01; hit_ready returns 1.
- Split:
  - Stimulus: after level start, hit slot 0 at x=100, y=200.
  - Cycle +1: load slot 0, x=84, size=2, xdir=0.
  - Cycle +2: load slot 1, x=116, size=2, xdir=1.
  - Final: active_mask=0x03, score=1.
- Saturation: hit at x=5 -> left child x=0. Hit at x=630 -> right child x=639.
- Pop to clear:
  - Stimulus: single ball forced to size 0 by repeated splits-and-pops until one slot remains, then hit it.
  - Required: score +4; active_mask=0; level_clear pulses exactly once, 2 cycles after accept.
- Overflow: fill all 8 slots, hit a size>0 ball -> SPLIT_A load occurs; overflow pulses; no second load; active_mask stays 0xFF.
- Corner cases:
  - startOfFrame coinciding with SPLIT_A -> load delayed exactly one cycle.
  - level_start simultaneous with hit_valid -> INIT wins and the hit is not accepted.
  - Hit on an inactive slot -> no effect.

Source files
------------

// File: rtl/ball_split_ctrl_if.sv
// rtl/ball_split_ctrl_if.sv - hit handshake and ball-bank load bus of the ball split controller
interface ball_split_ctrl_if;
    logic        hit_valid;
    logic [2:0]  hit_slot;
    logic [10:0] hit_x;
    logic [10:0] hit_y;
    logic        hit_ready;
    logic        load_valid;
    logic [2:0]  load_slot;
    logic [10:0] load_x;
    logic [10:0] load_y;
    logic        load_xdir;
    logic [1:0]  load_size;

    modport master (
        input  hit_valid, hit_slot, hit_x, hit_y,
        output hit_ready,
        output load_valid, load_slot, load_x, load_y, load_xdir, load_size
    );

    modport slave (
        output hit_valid, hit_slot, hit_x, hit_y,
        input  hit_ready,
        input  load_valid, load_slot, load_x, load_y, load_xdir, load_size
    );
endinterface

// File: rtl/ball_split_ctrl.sv
// rtl/ball_split_ctrl.sv - ball slot pool: level start, rope-hit split/pop, scoring, level clear
module ball_split_ctrl #(
    parameter int NUM_BALLS = 8,
    parameter int MAX_SIZE  = 3,
    parameter int INIT_X    = 26,
    parameter int INIT_Y    = 26,
    parameter int SPLIT_OFS = 16,
    parameter int X_MAX     = 639
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 level_start,
    ball_split_ctrl_if.master    bus,
    output logic [NUM_BALLS-1:0] active_mask,
    output logic [15:0]          score,
    output logic                 level_clear,
    output logic                 overflow
);
    typedef enum logic [2:0] {IDLE, INIT, SPLIT_A, SPLIT_B, POP, CHECK} state_t;

    localparam logic [10:0] OFS   = 11'(SPLIT_OFS);
    localparam logic [11:0] XLIM  = 12'(X_MAX);

    state_t      state;
    logic [7:0]  mask_q;
    logic [1:0]  size_q [8];
    logic [2:0]  lat_slot;
    logic [10:0] lat_x;
    logic [10:0] lat_y;
    logic [1:0]  lat_size;

    logic        free_found;
    logic [2:0]  free_slot;
    logic [10:0] left_x;
    logic [10:0] right_x;
    logic [11:0] right_sum;

    // Mask is kept 8 wide so a 3-bit slot index is always in range.
    assign active_mask = mask_q[NUM_BALLS-1:0];

    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (!mask_q[i]) begin
                free_found = 1'b1;
                free_slot  = 3'(i);
            end
        end
    end

    always_comb begin
        left_x    = (lat_x >= OFS) ? (lat_x - OFS) : 11'd0;
        right_sum = {1'b0, lat_x} + {1'b0, OFS};
        right_x   = (right_sum > XLIM) ? XLIM[10:0] : right_sum[10:0];
    end

    function automatic logic [15:0] sat_add(input logic [15:0] s, input logic [2:0] inc);
        logic [16:0] t;
        t = {1'b0, s} + {14'd0, inc};
        return t[16] ? 16'hFFFF : t[15:0];
    endfunction

    always_ff @(posedge clk) begin
        if (resetN) begin
            state         <= IDLE;
            mask_q        <= '0;
            score         <= '0;
            level_clear   <= 1'b0;
            overflow      <= 1'b0;
            bus.hit_ready <= 1'b0;
            bus.load_valid <= 1'b0;
            bus.load_slot <= '0;
            bus.load_x    <= '0;
            bus.load_y    <= '0;
            bus.load_xdir <= 1'b0;
            bus.load_size <= '0;
            lat_slot      <= '0;
            lat_x         <= '0;
            lat_y         <= '0;
            lat_size      <= '0;
            for (int i = 0; i < 8; i++) size_q[i] <= '0;
        end else begin
            bus.load_valid <= 1'b0;
            level_clear    <= 1'b0;
            overflow       <= 1'b0;
            if (level_start) begin
                state         <= INIT;
                mask_q        <= '0;
                bus.hit_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bus.hit_ready <= 1'b1;
                        if (bus.hit_valid && bus.hit_ready && mask_q[bus.hit_slot]) begin
                            lat_slot      <= bus.hit_slot;
                            lat_x         <= bus.hit_x;
                            lat_y         <= bus.hit_y;
                            lat_size      <= size_q[bus.hit_slot];
                            state         <= (size_q[bus.hit_slot] != 2'd0) ? SPLIT_A : POP;
                            bus.hit_ready <= 1'b0;
                        end
                    end
                    INIT: begin
                        if (!startOfFrame) begin
                            bus.load_valid <= 1'b1;
                            bus.load_slot  <= 3'd0;
                            bus.load_x     <= 11'(INIT_X);
                            bus.load_y     <= 11'(INIT_Y);
                            bus.load_xdir  <= 1'b1;
                            bus.load_size  <= 2'(MAX_SIZE);
                            size_q[0]      <= 2'(MAX_SIZE);
                            mask_q[0]      <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                    SPLIT_A: begin
                        if (!startOfFrame) begin
                            bus.load_valid   <= 1'b1;
                            bus.load_slot    <= lat_slot;
                            bus.load_x       <= left_x;
                            bus.load_y       <= lat_y;
                            bus.load_xdir    <= 1'b0;
                            bus.load_size    <= lat_size - 2'd1;
                            size_q[lat_slot] <= lat_size - 2'd1;
                            state            <= SPLIT_B;
                        end
                    end
                    SPLIT_B: begin
                        // With no free slot there is no load, so a frame pulse need not stall it.
                        if (!free_found) begin
                            overflow <= 1'b1;
                            score    <= sat_add(score, 3'd1);
                            state    <= IDLE;
                        end else if (!startOfFrame) begin
                            bus.load_valid    <= 1'b1;
                            bus.load_slot     <= free_slot;
                            bus.load_x        <= right_x;
                            bus.load_y        <= lat_y;
                            bus.load_xdir     <= 1'b1;
                            bus.load_size     <= lat_size - 2'd1;
                            size_q[free_slot] <= lat_size - 2'd1;
                            mask_q[free_slot] <= 1'b1;
                            score             <= sat_add(score, 3'd1);
                            state             <= IDLE;
                        end
                    end
                    POP: begin
                        mask_q[lat_slot] <= 1'b0;
                        score            <= sat_add(score, 3'd4);
                        state            <= CHECK;
                    end
                    CHECK: begin
                        level_clear <= (mask_q == 8'd0);
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ball_split_ctrl.sv
// tb/tb_ball_split_ctrl.sv - scoreboard bench for ball_split_ctrl
module tb_ball_split_ctrl;
    logic clk = 1'b0;
    logic resetN = 1'b1;
    logic sof = 1'b0;
    logic ls = 1'b0;
    logic ls2 = 1'b0;
    logic [7:0]  mask;
    logic [15:0] score;
    logic        lc;
    logic        ov;
    logic [3:0]  mask2;
    logic [15:0] score2;
    logic        lc2;
    logic        ov2;

    int total = 0;
    int bad = 0;
    int n_clear = 0;
    int n_ovf = 0;

    ball_split_ctrl_if bus ();
    ball_split_ctrl_if bus2 ();

    ball_split_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .level_start(ls),
        .bus(bus.master), .active_mask(mask), .score(score),
        .level_clear(lc), .overflow(ov)
    );

    ball_split_ctrl #(.NUM_BALLS(4)) dut2 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .level_start(ls2),
        .bus(bus2.master), .active_mask(mask2), .score(score2),
        .level_clear(lc2), .overflow(ov2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  slot;
        logic [10:0] x;
        logic [10:0] y;
        logic        xdir;
        logic [1:0]  size;
    } ld_t;

    ld_t        exp_q[$];
    logic [7:0] m_mask = '0;
    int         m_size[8];
    int         m_score = 0;
    int         m_clear = 0;
    int         m_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pack_ld(input int slot, input int x, input int y,
                                             input int xdir, input int size);
        ld_t e;
        e.slot = 3'(slot);
        e.x    = 11'(x);
        e.y    = 11'(y);
        e.xdir = 1'(xdir);
        e.size = 2'(size);
        return 32'(e);
    endfunction

    function automatic logic [31:0] dut_ld();
        return 32'({bus.load_slot, bus.load_x, bus.load_y, bus.load_xdir, bus.load_size});
    endfunction

    task automatic push_ld(input int slot, input int x, input int y, input int xdir, input int size);
        exp_q.push_back(ld_t'(pack_ld(slot, x, y, xdir, size)));
    endtask

    always @(negedge clk) begin
        if (bus.load_valid) begin
            if (exp_q.size() == 0) chk("load_extra", dut_ld(), 32'hFFFF_FFFF);
            else chk("load", dut_ld(), 32'(exp_q.pop_front()));
        end
        if (lc) n_clear++;
        if (ov) n_ovf++;
    end

    task automatic model_hit(input int slot, input int x, input int y);
        int sz;
        int f;
        if (!m_mask[slot]) return;
        if (m_size[slot] > 0) begin
            sz = m_size[slot] - 1;
            push_ld(slot, (x < 16) ? 0 : x - 16, y, 0, sz);
            m_size[slot] = sz;
            f = -1;
            for (int i = 7; i >= 0; i--) if (!m_mask[i]) f = i;
            if (f >= 0) begin
                push_ld(f, (x + 16 > 639) ? 639 : x + 16, y, 1, sz);
                m_mask[f] = 1'b1;
                m_size[f] = sz;
            end else begin
                m_ovf++;
            end
            m_score = (m_score + 1 > 65535) ? 65535 : m_score + 1;
        end else begin
            m_mask[slot] = 1'b0;
            m_score = (m_score + 4 > 65535) ? 65535 : m_score + 4;
            if (m_mask == 8'd0) m_clear++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.hit_ready && n < 20) begin
            step();
            n++;
        end
        if (!bus.hit_ready) chk("ready_timeout", 32'(bus.hit_ready), 1);
    endtask

    task automatic do_level(input bit with_hit);
        wait_ready();
        ls = 1'b1;
        if (with_hit) begin
            bus.hit_valid = 1'b1;
            bus.hit_slot  = 3'd0;
            bus.hit_x     = 11'd300;
            bus.hit_y     = 11'd300;
        end
        push_ld(0, 26, 26, 1, 3);
        m_mask = 8'h01;
        m_size[0] = 3;
        step();
        ls = 1'b0;
        bus.hit_valid = 1'b0;
        wait_ready();
    endtask

    task automatic do_hit(input int slot, input int x, input int y);
        wait_ready();
        bus.hit_valid = 1'b1;
        bus.hit_slot  = 3'(slot);
        bus.hit_x     = 11'(x);
        bus.hit_y     = 11'(y);
        model_hit(slot, x, y);
        step();
        bus.hit_valid = 1'b0;
    endtask

    task automatic hit2(input int slot, input int x);
        int n = 0;
        while (!bus2.hit_ready && n < 20) begin
            step();
            n++;
        end
        if (!bus2.hit_ready) chk("ready2_timeout", 32'(bus2.hit_ready), 1);
        bus2.hit_valid = 1'b1;
        bus2.hit_slot  = 3'(slot);
        bus2.hit_x     = 11'(x);
        bus2.hit_y     = 11'd40;
        step();
        bus2.hit_valid = 1'b0;
    endtask

    initial begin
        int pops[11] = '{2, 4, 0, 1, 3, 0, 1, 2, 3, 4, 5};
        bus.hit_valid = 1'b0; bus.hit_slot = '0; bus.hit_x = '0; bus.hit_y = '0;
        bus2.hit_valid = 1'b0; bus2.hit_slot = '0; bus2.hit_x = '0; bus2.hit_y = '0;
        for (int i = 0; i < 8; i++) m_size[i] = 0;

        step(); step();
        chk("rst_ready", 32'(bus.hit_ready), 0);
        chk("rst_load", 32'(bus.load_valid), 0);
        chk("rst_mask", 32'(mask), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_flags", 32'({lc, ov}), 0);
        resetN = 1'b0;

        do_level(1'b0);
        chk("lvl_mask", 32'(mask), 32'(m_mask));
        chk("lvl_ready", 32'(bus.hit_ready), 1);

        do_level(1'b1);
        step();
        chk("ls_hit_mask", 32'(mask), 32'h01);
        chk("ls_hit_score", 32'(score), 0);

        do_hit(0, 100, 200);
        chk("split_acc_ready", 32'(bus.hit_ready), 0);
        chk("split_acc_load", 32'(bus.load_valid), 0);
        step();
        chk("split_a", {bus.load_valid, dut_ld()}, {1'b1, pack_ld(0, 84, 200, 0, 2)});
        step();
        chk("split_b", {bus.load_valid, dut_ld()}, {1'b1, pack_ld(1, 116, 200, 1, 2)});
        step();
        chk("split_ready", 32'(bus.hit_ready), 1);
        chk("split_mask", 32'(mask), 32'h03);
        chk("split_score", 32'(score), 1);

        do_hit(0, 5, 10);
        do_hit(1, 630, 10);
        wait_ready();
        chk("sat_mask", 32'(mask), 32'h0F);

        do_hit(2, 300, 50);
        sof = 1'b1;
        step();
        sof = 1'b0;
        chk("sof_stall", 32'(bus.load_valid), 0);
        step();
        chk("sof_a", {bus.load_valid, dut_ld()}, {1'b1, pack_ld(2, 284, 50, 0, 0)});
        step();
        chk("sof_b", {bus.load_valid, dut_ld()}, {1'b1, pack_ld(4, 316, 50, 1, 0)});
        wait_ready();
        chk("sof_mask", 32'(mask), 32'(m_mask));

        do_hit(7, 50, 50);
        chk("inact_ready", 32'(bus.hit_ready), 1);
        step(); step();
        chk("inact_mask", 32'(mask), 32'(m_mask));
        chk("inact_score", 32'(score), 32'(m_score));

        for (int i = 0; i < 10; i++) do_hit(pops[i], 200 + 10 * i, 100);
        wait_ready();
        chk("pre_pop_mask", 32'(mask), 32'h20);
        chk("pre_pop_clear", 32'(n_clear), 0);
        do_hit(pops[10], 400, 100);
        chk("pop_acc_clear", 32'(lc), 0);
        step();
        chk("pop_mask", 32'(mask), 0);
        chk("pop_early_clear", 32'(lc), 0);
        step();
        chk("pop_clear", 32'(lc), 1);
        step();
        chk("pop_clear_end", 32'(lc), 0);
        chk("pop_ready", 32'(bus.hit_ready), 1);
        chk("pop_score", 32'(score), 32'(m_score));
        chk("clear_count", 32'(n_clear), 32'(m_clear));
        chk("ovf_count", 32'(n_ovf), 32'(m_ovf));
        chk("queue_empty", 32'(exp_q.size()), 0);

        do_level(1'b0);
        step();
        do_hit(0, 100, 100);
        resetN = 1'b1;
        step();
        exp_q.delete();
        chk("midrst_load", 32'(bus.load_valid), 0);
        chk("midrst_mask", 32'(mask), 0);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_ready", 32'(bus.hit_ready), 0);
        resetN = 1'b0;

        ls2 = 1'b1;
        step();
        ls2 = 1'b0;
        hit2(0, 100);
        hit2(0, 100);
        hit2(1, 100);
        hit2(2, 200);
        step();
        chk("ovf_a", {bus2.load_valid, 32'({bus2.load_slot, bus2.load_x, bus2.load_y,
            bus2.load_xdir, bus2.load_size})}, {1'b1, pack_ld(2, 184, 40, 0, 0)});
        step();
        chk("ovf_pulse", 32'({ov2, bus2.load_valid}), 32'b10);
        step();
        chk("ovf_end", 32'({ov2, bus2.load_valid, bus2.hit_ready}), 32'b001);
        chk("ovf_mask", 32'(mask2), 32'h0F);
        chk("ovf_score", 32'(score2), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
